// File: rtl/xbus_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// xbus_arbiter_pkg
// Shared definitions for the xbus arbiter: FSM state encodings, the
// "no owner" master index, hold-flag levels, reset polarity and a small
// modulo-increment helper used for the round-robin pointer.
// ---------------------------------------------------------------------------
package xbus_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OWN     = 2'd1,
    RELEASE = 2'd2
  } xbus_state_e;

  localparam logic [4:0] NoMaster    = 5'd31;
  localparam logic       HoldEnable  = 1'b1;
  localparam logic       HoldDisable = 1'b0;
  localparam logic       RstEnable   = 1'b1;

  // (v + 1) mod n, for v in 0..n-1 and n in 2..31.
  function automatic logic [4:0] wrap_inc(input logic [4:0] v, input int unsigned n);
    logic [4:0] r;
    if (v == 5'(n - 1)) begin
      r = 5'd0;
    end else begin
      r = v + 5'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/xbus_arbiter_xrr_pick.sv
// ---------------------------------------------------------------------------
// xrr_pick
// Combinational round-robin picker. Searches req upward starting at ptr,
// wrapping modulo N, and returns the first set index.
//   req : N-bit request vector (bit i = master i)
//   ptr : 5-bit search start index, expected in 0..N-1
//   idx : winning index (NoMaster when nothing is requested)
//   any : 1 when at least one request bit is set
// ---------------------------------------------------------------------------
module xrr_pick
  import xbus_arbiter_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0] req,
  input  logic [4:0]   ptr,
  output logic [4:0]   idx,
  output logic         any
);

  // Widened copy so a 5-bit index never over-reaches the request vector.
  logic [31:0] req_ext;
  logic [5:0]  cand;

  assign req_ext = 32'(req);

  // First-set search starting at ptr with modulo-N wrap.
  always_comb begin
    idx  = NoMaster;
    any  = 1'b0;
    cand = 6'd0;
    for (int k = 0; k < N; k++) begin
      cand = {1'b0, ptr} + 6'(k);
      if (cand >= 6'(N)) begin
        cand = cand - 6'(N);
      end else begin
        cand = cand;
      end
      if (!any && req_ext[cand[4:0]]) begin
        any = 1'b1;
        idx = cand[4:0];
      end else begin
        any = any;
      end
    end
  end

endmodule

// File: rtl/xbus_arbiter.sv
// ---------------------------------------------------------------------------
// xbus_arbiter
// Round-robin bus arbiter with locked bursts and an idle timeout.
//   clk           : sole clock, rising edge
//   rst           : asynchronous active-high reset
//   req_in        : per-master bus request
//   lock_in       : per-master request to keep the bus after a transaction
//   done_in       : single-cycle transaction-complete pulse from the slave
//   grant_out     : one-hot grant, zero when there is no owner
//   master_id_out : owner index, NoMaster when there is no owner
//   hold_flag_out : HoldEnable while a master owns the bus
//   timeout_out   : one-cycle pulse on forced release
// ---------------------------------------------------------------------------
module xbus_arbiter
  import xbus_arbiter_pkg::*;
#(
  parameter int MASTER_NUM = 8,
  parameter int MAX_BURST  = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [MASTER_NUM-1:0] req_in,
  input  logic [MASTER_NUM-1:0] lock_in,
  input  logic                  done_in,
  output logic [MASTER_NUM-1:0] grant_out,
  output logic [4:0]            master_id_out,
  output logic                  hold_flag_out,
  output logic                  timeout_out
);

  localparam logic [MASTER_NUM-1:0] OneHotBase = {{(MASTER_NUM-1){1'b0}}, 1'b1};

  xbus_state_e           state_q, state_d;
  logic [MASTER_NUM-1:0] grant_q, grant_d;
  logic [4:0]            master_id_q, master_id_d;
  logic                  hold_q, hold_d;
  logic                  timeout_q, timeout_d;
  logic [4:0]            owner_q, owner_d;
  logic [4:0]            rr_ptr_q, rr_ptr_d;
  logic [3:0]            burst_cnt_q, burst_cnt_d;
  logic [7:0]            wait_cnt_q, wait_cnt_d;

  logic [4:0]  pick_idx;
  logic        pick_any;
  logic [31:0] req_ext;
  logic [31:0] lock_ext;
  logic        owner_req;
  logic        owner_lock;

  xrr_pick #(.N(MASTER_NUM)) u_pick (
    .req (req_in),
    .ptr (rr_ptr_q),
    .idx (pick_idx),
    .any (pick_any)
  );

  assign req_ext    = 32'(req_in);
  assign lock_ext   = 32'(lock_in);
  assign owner_req  = req_ext[owner_q];
  assign owner_lock = lock_ext[owner_q];

  // Next-state and next-output logic; outputs are registered, so every
  // transition into RELEASE clears the grant on the same edge.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    master_id_d = master_id_q;
    hold_d      = hold_q;
    timeout_d   = 1'b0;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = burst_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d     = OWN;
          grant_d     = OneHotBase << pick_idx;
          master_id_d = pick_idx;
          hold_d      = HoldEnable;
          owner_d     = pick_idx;
          burst_cnt_d = 4'd0;
          wait_cnt_d  = 8'd0;
        end else begin
          grant_d     = '0;
          master_id_d = NoMaster;
          hold_d      = HoldDisable;
        end
      end
      OWN: begin
        // Priority: done, then abort (owner dropped req), then timeout.
        if (done_in) begin
          wait_cnt_d = 8'd0;
          if (owner_req && owner_lock && (burst_cnt_q < 4'(MAX_BURST - 1))) begin
            burst_cnt_d = burst_cnt_q + 4'd1;
          end else begin
            state_d     = RELEASE;
            grant_d     = '0;
            master_id_d = NoMaster;
            hold_d      = HoldDisable;
          end
        end else if (!owner_req) begin
          state_d     = RELEASE;
          grant_d     = '0;
          master_id_d = NoMaster;
          hold_d      = HoldDisable;
        end else if ((wait_cnt_q + 8'd1) == 8'(TIMEOUT)) begin
          // This is the TIMEOUT-th idle OWN cycle: force release and pulse.
          wait_cnt_d  = wait_cnt_q + 8'd1;
          state_d     = RELEASE;
          grant_d     = '0;
          master_id_d = NoMaster;
          hold_d      = HoldDisable;
          timeout_d   = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      RELEASE: begin
        state_d     = IDLE;
        grant_d     = '0;
        master_id_d = NoMaster;
        hold_d      = HoldDisable;
        rr_ptr_d    = wrap_inc(owner_q, MASTER_NUM);
        burst_cnt_d = 4'd0;
        wait_cnt_d  = 8'd0;
      end
      default: begin
        state_d     = IDLE;
        grant_d     = '0;
        master_id_d = NoMaster;
        hold_d      = HoldDisable;
        burst_cnt_d = 4'd0;
        wait_cnt_d  = 8'd0;
      end
    endcase
  end

  // State, counter and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      master_id_q <= NoMaster;
      hold_q      <= HoldDisable;
      timeout_q   <= 1'b0;
      owner_q     <= 5'd0;
      rr_ptr_q    <= 5'd0;
      burst_cnt_q <= 4'd0;
      wait_cnt_q  <= 8'd0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      master_id_q <= master_id_d;
      hold_q      <= hold_d;
      timeout_q   <= timeout_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
    end
  end

  assign grant_out     = grant_q;
  assign master_id_out = master_id_q;
  assign hold_flag_out = hold_q;
  assign timeout_out   = timeout_q;

endmodule

// File: tb/tb_xbus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_xbus_arbiter
// Directed self-checking bench for xbus_arbiter with default parameters
// (8 masters, bursts of 4, timeout 255). Inputs change and outputs are
// sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_xbus_arbiter;

  logic       clk;
  logic       rst;
  logic [7:0] req_in;
  logic [7:0] lock_in;
  logic       done_in;
  logic [7:0] grant_out;
  logic [4:0] master_id_out;
  logic       hold_flag_out;
  logic       timeout_out;

  int checks;
  int errors;

  xbus_arbiter #(.MASTER_NUM(8), .MAX_BURST(4), .TIMEOUT(255)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_in        (req_in),
    .lock_in       (lock_in),
    .done_in       (done_in),
    .grant_out     (grant_out),
    .master_id_out (master_id_out),
    .hold_flag_out (hold_flag_out),
    .timeout_out   (timeout_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst     = 1'b1;
    req_in  = 8'h00;
    lock_in = 8'h00;
    done_in = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst     = 1'b0;
    req_in  = 8'h00;
    lock_in = 8'h00;
    done_in = 1'b0;
    #1 rst = 1'b1;
    #1;
    checks++;
    if (grant_out !== 8'h00 || master_id_out !== 5'd31 || hold_flag_out !== 1'b0 || timeout_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: got grant=%h id=%0d hold=%b to=%b, want 00/31/0/0",
               grant_out, master_id_out, hold_flag_out, timeout_out);
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
    checks++;
    if (grant_out !== 8'h00 || master_id_out !== 5'd31 || hold_flag_out !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_req: got grant=%h id=%0d hold=%b, want 00/31/0",
               grant_out, master_id_out, hold_flag_out);
    end
  endtask

  task automatic test_single();
    do_reset();
    req_in = 8'h01;
    tick();
    checks++;
    if (grant_out !== 8'h01 || master_id_out !== 5'd0 || hold_flag_out !== 1'b1) begin
      errors++;
      $display("FAIL single_grant: got grant=%h id=%0d hold=%b, want 01/0/1",
               grant_out, master_id_out, hold_flag_out);
    end
    req_in  = 8'h00;
    done_in = 1'b1;
    tick();
    done_in = 1'b0;
    checks++;
    if (grant_out !== 8'h00 || master_id_out !== 5'd31 || hold_flag_out !== 1'b0 || timeout_out !== 1'b0) begin
      errors++;
      $display("FAIL single_release: got grant=%h id=%0d hold=%b to=%b, want 00/31/0/0",
               grant_out, master_id_out, hold_flag_out, timeout_out);
    end
  endtask

  task automatic test_abort();
    do_reset();
    req_in = 8'h02;
    tick();
    req_in = 8'h00;
    tick();
    checks++;
    if (master_id_out !== 5'd31 || grant_out !== 8'h00 || timeout_out !== 1'b0) begin
      errors++;
      $display("FAIL abort_release: got id=%0d grant=%h to=%b, want 31/00/0",
               master_id_out, grant_out, timeout_out);
    end
  endtask

  task automatic test_round_robin();
    logic [4:0] exp_id [4];
    exp_id[0] = 5'd0; exp_id[1] = 5'd3; exp_id[2] = 5'd0; exp_id[3] = 5'd3;
    do_reset();
    req_in = 8'h09;
    tick();
    for (int g = 0; g < 4; g++) begin
      checks++;
      if (master_id_out !== exp_id[g] || grant_out !== (8'h01 << exp_id[g]) || hold_flag_out !== 1'b1) begin
        errors++;
        $display("FAIL rr_grant%0d: got id=%0d grant=%h hold=%b, want id=%0d",
                 g, master_id_out, grant_out, hold_flag_out, exp_id[g]);
      end
      tick();
      checks++;
      if (master_id_out !== exp_id[g]) begin
        errors++;
        $display("FAIL rr_hold%0d: got id=%0d, want %0d", g, master_id_out, exp_id[g]);
      end
      done_in = 1'b1;
      tick();
      done_in = 1'b0;
      checks++;
      if (hold_flag_out !== 1'b0 || grant_out !== 8'h00) begin
        errors++;
        $display("FAIL rr_gap1_%0d: got hold=%b grant=%h, want 0/00", g, hold_flag_out, grant_out);
      end
      tick();
      checks++;
      if (hold_flag_out !== 1'b0 || master_id_out !== 5'd31) begin
        errors++;
        $display("FAIL rr_gap2_%0d: got hold=%b id=%0d, want 0/31", g, hold_flag_out, master_id_out);
      end
      tick();
    end
  endtask

  task automatic test_burst_lock();
    do_reset();
    req_in  = 8'h06;
    lock_in = 8'h02;
    tick();
    checks++;
    if (master_id_out !== 5'd1 || grant_out !== 8'h02) begin
      errors++;
      $display("FAIL burst_first: got id=%0d grant=%h, want 1/02", master_id_out, grant_out);
    end
    for (int p = 0; p < 4; p++) begin
      done_in = 1'b1;
      tick();
      done_in = 1'b0;
      if (p < 3) begin
        checks++;
        if (master_id_out !== 5'd1 || hold_flag_out !== 1'b1) begin
          errors++;
          $display("FAIL burst_keep%0d: got id=%0d hold=%b, want 1/1", p, master_id_out, hold_flag_out);
        end
      end
    end
    checks++;
    if (master_id_out !== 5'd31 || hold_flag_out !== 1'b0) begin
      errors++;
      $display("FAIL burst_release: got id=%0d hold=%b, want 31/0", master_id_out, hold_flag_out);
    end
    tick();
    tick();
    checks++;
    if (master_id_out !== 5'd2 || grant_out !== 8'h04) begin
      errors++;
      $display("FAIL burst_next: got id=%0d grant=%h, want 2/04", master_id_out, grant_out);
    end
  endtask

  task automatic test_timeout();
    int own_cycles;
    int early_pulse;
    do_reset();
    req_in = 8'h60;
    tick();
    own_cycles  = 0;
    early_pulse = 0;
    for (int k = 0; k < 300; k++) begin
      if (master_id_out == 5'd5) begin
        own_cycles++;
        if (timeout_out !== 1'b0) early_pulse++;
        tick();
      end else begin
        break;
      end
    end
    checks++;
    if (own_cycles != 255 || early_pulse != 0) begin
      errors++;
      $display("FAIL timeout_len: got %0d own cycles (%0d early pulses), want 255 (0)", own_cycles, early_pulse);
    end
    checks++;
    if (timeout_out !== 1'b1 || master_id_out !== 5'd31) begin
      errors++;
      $display("FAIL timeout_pulse: got to=%b id=%0d, want 1/31", timeout_out, master_id_out);
    end
    tick();
    checks++;
    if (timeout_out !== 1'b0) begin
      errors++;
      $display("FAIL timeout_width: got to=%b, want 0", timeout_out);
    end
    tick();
    checks++;
    if (master_id_out !== 5'd6 || grant_out !== 8'h40) begin
      errors++;
      $display("FAIL timeout_next: got id=%0d grant=%h, want 6/40", master_id_out, grant_out);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    req_in = 8'h0C;
    tick();
    done_in = 1'b1;
    tick();
    done_in = 1'b0;
    tick();
    tick();
    checks++;
    if (master_id_out !== 5'd3) begin
      errors++;
      $display("FAIL areset_setup: got id=%0d, want 3", master_id_out);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (grant_out !== 8'h00 || master_id_out !== 5'd31 || hold_flag_out !== 1'b0 || timeout_out !== 1'b0) begin
      errors++;
      $display("FAIL areset_immediate: got grant=%h id=%0d hold=%b to=%b, want 00/31/0/0",
               grant_out, master_id_out, hold_flag_out, timeout_out);
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
    checks++;
    if (master_id_out !== 5'd2 || grant_out !== 8'h04 || timeout_out !== 1'b0) begin
      errors++;
      $display("FAIL areset_first: got id=%0d grant=%h to=%b, want 2/04/0",
               master_id_out, grant_out, timeout_out);
    end
  endtask

  task automatic test_done_with_drop();
    do_reset();
    req_in  = 8'h10;
    lock_in = 8'h10;
    tick();
    req_in  = 8'h00;
    done_in = 1'b1;
    tick();
    done_in = 1'b0;
    checks++;
    if (master_id_out !== 5'd31 || timeout_out !== 1'b0 || hold_flag_out !== 1'b0) begin
      errors++;
      $display("FAIL done_drop: got id=%0d to=%b hold=%b, want 31/0/0",
               master_id_out, timeout_out, hold_flag_out);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single();
    test_abort();
    test_round_robin();
    test_burst_lock();
    test_timeout();
    test_async_reset();
    test_done_with_drop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
